// File: rtl/usb_rx_packet.sv
// USB receive packet decoder: classifies packets by PID, forwards DATA payload with CRC16 stripped, reports status.
// Optional: define USB_RX_CRC5_EN to also check the CRC5 of token packets.
module usb_rx_packet #(
  parameter int MAX_LEN = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_active,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_error,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        pkt_done,
  output logic        pkt_ok,
  output logic [3:0]  pkt_pid,
  output logic [10:0] pkt_len
);

  localparam logic [2:0] SYNC  = 3'd0;
  localparam logic [2:0] IDLE  = 3'd1;
  localparam logic [2:0] PID   = 3'd2;
  localparam logic [2:0] DATA  = 3'd3;
  localparam logic [2:0] TOKEN = 3'd4;
  localparam logic [2:0] HSK   = 3'd5;
  localparam logic [2:0] DRAIN = 3'd6;
  localparam logic [2:0] DONE  = 3'd7;

  logic [2:0]  state_q, state_d;
  logic        err_q, err_d;
  logic [3:0]  pid_q, pid_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] crc_q, crc_d;
  logic [7:0]  dly0_q, dly0_d;
  logic [7:0]  dly1_q, dly1_d;
  logic [10:0] len_q, len_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        pkt_done_q, pkt_done_d;
  logic        pkt_ok_q, pkt_ok_d;
  logic [3:0]  pkt_pid_q, pkt_pid_d;
  logic [10:0] pkt_len_q, pkt_len_d;
`ifdef USB_RX_CRC5_EN
  logic [4:0]  crc5_q, crc5_d;
`endif

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 16'hA001;
      else             r = r >> 1;
    end
    return r;
  endfunction

`ifdef USB_RX_CRC5_EN
  function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] b);
    logic [4:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 5'h14;
      else             r = r >> 1;
    end
    return r;
  endfunction
`endif

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    pid_d       = pid_q;
    cnt_d       = cnt_q;
    crc_d       = crc_q;
    dly0_d      = dly0_q;
    dly1_d      = dly1_q;
    len_d       = len_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    pkt_done_d  = 1'b0;
    pkt_ok_d    = pkt_ok_q;
    pkt_pid_d   = pkt_pid_q;
    pkt_len_d   = pkt_len_q;
`ifdef USB_RX_CRC5_EN
    crc5_d      = crc5_q;
`endif
    case (state_q)
      SYNC: if (!rx_active) state_d = IDLE;
      // DONE doubles as IDLE so a packet starting right after EOP is not missed.
      IDLE, DONE: begin
        if (state_q == DONE) begin
          pkt_done_d = 1'b1;
          pkt_ok_d   = ~err_q;
          pkt_pid_d  = pid_q;
          pkt_len_d  = len_q;
        end
        err_d   = rx_active & rx_error;
        pid_d   = 4'd0;
        cnt_d   = 2'd0;
        crc_d   = 16'hFFFF;
        len_d   = 11'd0;
`ifdef USB_RX_CRC5_EN
        crc5_d  = 5'h1F;
`endif
        state_d = rx_active ? PID : IDLE;
      end
      PID: begin
        err_d = err_q | rx_error;
        if (!rx_active) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (rx_valid) begin
          pid_d = rx_data[3:0];
          if (rx_data[7:4] != ~rx_data[3:0]) begin
            err_d   = 1'b1;
            state_d = DRAIN;
          end else begin
            case (rx_data[1:0])
              2'b11: begin
                if (!rx_data[2]) state_d = DATA;
                else begin
                  err_d   = 1'b1;
                  state_d = DRAIN;
                end
              end
              2'b01:   state_d = TOKEN;
              2'b10:   state_d = HSK;
              default: begin
                err_d   = 1'b1;
                state_d = DRAIN;
              end
            endcase
          end
        end
      end
      DATA, TOKEN, HSK, DRAIN: begin
        err_d = err_q | rx_error;
        if (!rx_active) begin
          state_d = DONE;
          if (state_q == DATA && (!cnt_q[1] || crc_q != 16'hB001)) err_d = 1'b1;
          if (state_q == TOKEN && cnt_q != 2'd2) err_d = 1'b1;
          if (state_q == HSK && cnt_q != 2'd0) err_d = 1'b1;
`ifdef USB_RX_CRC5_EN
          if (state_q == TOKEN && crc5_q != 5'h06) err_d = 1'b1;
`endif
        end else if (rx_valid) begin
          cnt_d = (cnt_q == 2'd3) ? cnt_q : cnt_q + 2'd1;
          // The two newest bytes stay in the delay line; they become the CRC at EOP.
          if (state_q == DATA) begin
            crc_d  = crc16_byte(crc_q, rx_data);
            dly0_d = rx_data;
            dly1_d = dly0_q;
            if (cnt_q[1]) begin
              if (len_q == 11'(MAX_LEN)) err_d = 1'b1;
              else begin
                out_data_d  = dly1_q;
                out_valid_d = 1'b1;
                len_d       = len_q + 11'd1;
              end
            end
          end
`ifdef USB_RX_CRC5_EN
          if (state_q == TOKEN && !cnt_q[1]) crc5_d = crc5_byte(crc5_q, rx_data);
`endif
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= SYNC;
      err_q       <= 1'b0;
      pid_q       <= 4'd0;
      cnt_q       <= 2'd0;
      crc_q       <= 16'hFFFF;
      dly0_q      <= 8'd0;
      dly1_q      <= 8'd0;
      len_q       <= 11'd0;
      out_data_q  <= 8'd0;
      out_valid_q <= 1'b0;
      pkt_done_q  <= 1'b0;
      pkt_ok_q    <= 1'b0;
      pkt_pid_q   <= 4'd0;
      pkt_len_q   <= 11'd0;
`ifdef USB_RX_CRC5_EN
      crc5_q      <= 5'h1F;
`endif
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      pid_q       <= pid_d;
      cnt_q       <= cnt_d;
      crc_q       <= crc_d;
      dly0_q      <= dly0_d;
      dly1_q      <= dly1_d;
      len_q       <= len_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      pkt_done_q  <= pkt_done_d;
      pkt_ok_q    <= pkt_ok_d;
      pkt_pid_q   <= pkt_pid_d;
      pkt_len_q   <= pkt_len_d;
`ifdef USB_RX_CRC5_EN
      crc5_q      <= crc5_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign pkt_done  = pkt_done_q;
  assign pkt_ok    = pkt_ok_q;
  assign pkt_pid   = pkt_pid_q;
  assign pkt_len   = pkt_len_q;

endmodule

// File: tb/tb_usb_rx_packet.sv
// Testbench for usb_rx_packet: directed and random packets checked against a packet-level reference model.
// Honors USB_RX_CRC5_EN the same way the design does.
module tb_usb_rx_packet;

  localparam int MAX_LEN = 1023;
  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_active = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_error = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        pkt_done;
  logic        pkt_ok;
  logic [3:0]  pkt_pid;
  logic [10:0] pkt_len;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  // Observed and expected streams, compared batch by batch.
  logic [7:0]  obs_data[$];
  int          obs_dcyc[$];
  logic        obs_ok[$];
  logic [3:0]  obs_pid[$];
  logic [10:0] obs_len[$];
  int          obs_cyc[$];
  logic [7:0]  exp_data[$];
  int          exp_dcyc[$];
  logic        exp_ok[$];
  logic [3:0]  exp_pid[$];
  logic [10:0] exp_len[$];
  int          exp_cyc[$];

  usb_rx_packet #(.MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .reset(reset), .rx_active(rx_active), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_error(rx_error), .out_data(out_data), .out_valid(out_valid),
    .pkt_done(pkt_done), .pkt_ok(pkt_ok), .pkt_pid(pkt_pid), .pkt_len(pkt_len)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) begin
      obs_data.push_back(out_data);
      obs_dcyc.push_back(cyc);
    end
    if (pkt_done) begin
      obs_ok.push_back(pkt_ok);
      obs_pid.push_back(pkt_pid);
      obs_len.push_back(pkt_len);
      obs_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc16(input bq_t b, input int first, input int last);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int k = first; k <= last; k++)
      for (int j = 0; j < 8; j++)
        if (c[0] ^ b[k][j]) c = (c >> 1) ^ 16'hA001;
        else                c = c >> 1;
    return c;
  endfunction

  function automatic logic [4:0] crc5_field(input logic [10:0] f);
    logic [4:0] c;
    c = 5'h1F;
    for (int j = 0; j < 11; j++)
      if (c[0] ^ f[j]) c = (c >> 1) ^ 5'h14;
      else             c = c >> 1;
    return c;
  endfunction

  function automatic bq_t makeData(input logic [7:0] pid, input bq_t pl, input bit corrupt);
    bq_t b;
    logic [15:0] c;
    b.push_back(pid);
    foreach (pl[i]) b.push_back(pl[i]);
    c = ~crc16(pl, 0, pl.size() - 1);
    b.push_back(c[7:0]);
    b.push_back(corrupt ? ~c[15:8] : c[15:8]);
    return b;
  endfunction

  function automatic bq_t makeToken(input logic [7:0] pid, input logic [10:0] fld, input bit corrupt);
    bq_t b;
    logic [4:0] c;
    c = ~crc5_field(fld);
    if (corrupt) c = c ^ 5'h01;
    b.push_back(pid);
    b.push_back(fld[7:0]);
    b.push_back({c, fld[10:8]});
    return b;
  endfunction

  // Packet-level reference: what the endpoint should see for a given byte sequence.
  task automatic modelPacket(input bq_t b, input bit err, output int fwd);
    logic [7:0]  p;
    logic [3:0]  pid;
    logic [15:0] c;
    bit          ok;
    int          rest;
`ifdef USB_RX_CRC5_EN
    logic [10:0] fld;
    logic [7:0]  b2;
`endif
    fwd = 0;
    ok  = 1'b0;
    pid = 4'd0;
    if (b.size() > 0) begin
      p    = b[0];
      pid  = p[3:0];
      rest = b.size() - 1;
      if (p[7:4] != ~p[3:0]) ok = 1'b0;
      else if (p[1:0] == 2'b11 && !p[2]) begin
        ok  = (rest >= 2);
        fwd = (rest >= 2) ? rest - 2 : 0;
        if (fwd > MAX_LEN) begin
          fwd = MAX_LEN;
          ok  = 1'b0;
        end
        if (rest >= 2) begin
          c = ~crc16(b, 1, rest - 2);
          if (b[rest - 1] != c[7:0] || b[rest] != c[15:8]) ok = 1'b0;
        end
        for (int k = 1; k <= fwd; k++) exp_data.push_back(b[k]);
      end else if (p[1:0] == 2'b01) begin
        ok = (rest == 2);
`ifdef USB_RX_CRC5_EN
        if (rest == 2) begin
          b2  = b[2];
          fld = {b2[2:0], b[1]};
          if (b2[7:3] != ~crc5_field(fld)) ok = 1'b0;
        end
`endif
      end else if (p[1:0] == 2'b10) ok = (rest == 0);
      else ok = 1'b0;
    end
    if (err) ok = 1'b0;
    exp_ok.push_back(ok);
    exp_pid.push_back(pid);
    exp_len.push_back(11'(fwd));
  endtask

  // Drives one packet; err_idx selects the byte carrying rx_error (b.size() = the falling cycle, -1 = none).
  task automatic applyStimulus(input bq_t b, input int err_idx, input int low_cycles);
    int dc[$];
    int fwd;
    modelPacket(b, err_idx >= 0, fwd);
    rx_active = 1'b1;
    tick();
    tick();
    foreach (b[i]) begin
      rx_valid = 1'b1;
      rx_data  = b[i];
      rx_error = (i == err_idx);
      dc.push_back(cyc);
      tick();
      rx_valid = 1'b0;
      rx_error = 1'b0;
      if ($urandom_range(3) == 0) tick();
    end
    for (int k = 0; k < fwd; k++) exp_dcyc.push_back(dc[k + 3] + 1);
    rx_active = 1'b0;
    rx_error  = (err_idx == b.size());
    rx_valid  = 1'($urandom_range(1));
    rx_data   = 8'($urandom);
    exp_cyc.push_back(cyc + 2);
    tick();
    rx_valid = 1'b0;
    rx_error = 1'b0;
    repeat (low_cycles - 1) tick();
  endtask

  task automatic checkBatch(input string tag);
    int waitc = 0;
    int n;
    while (obs_ok.size() < exp_ok.size() && waitc < 60) begin
      tick();
      waitc++;
    end
    repeat (3) tick();
    checkOutput({tag, "_done_count"}, obs_ok.size(), exp_ok.size());
    n = (obs_ok.size() < exp_ok.size()) ? obs_ok.size() : exp_ok.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_ok%0d", tag, i), obs_ok[i], exp_ok[i]);
      checkOutput($sformatf("%s_pid%0d", tag, i), obs_pid[i], exp_pid[i]);
      checkOutput($sformatf("%s_len%0d", tag, i), obs_len[i], exp_len[i]);
      checkOutput($sformatf("%s_done_cyc%0d", tag, i), obs_cyc[i], exp_cyc[i]);
    end
    checkOutput({tag, "_byte_count"}, obs_data.size(), exp_data.size());
    n = (obs_data.size() < exp_data.size()) ? obs_data.size() : exp_data.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_byte%0d", tag, i), obs_data[i], exp_data[i]);
      checkOutput($sformatf("%s_byte_cyc%0d", tag, i), obs_dcyc[i], exp_dcyc[i]);
    end
    obs_data.delete(); obs_dcyc.delete(); obs_ok.delete(); obs_pid.delete();
    obs_len.delete(); obs_cyc.delete(); exp_data.delete(); exp_dcyc.delete();
    exp_ok.delete(); exp_pid.delete(); exp_len.delete(); exp_cyc.delete();
  endtask

  task automatic resetMidPacket();
    bq_t b;
    b = '{8'hC3, 8'h11, 8'h22};
    rx_active = 1'b1;
    tick();
    tick();
    foreach (b[i]) begin
      rx_valid = 1'b1;
      rx_data  = b[i];
      tick();
    end
    rx_valid = 1'b0;
    reset = 1'b0;
    tick();
    checkOutput("midrst_out_data", out_data, 0);
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_pkt_done", pkt_done, 0);
    checkOutput("midrst_pkt_ok", pkt_ok, 0);
    checkOutput("midrst_pkt_pid", pkt_pid, 0);
    checkOutput("midrst_pkt_len", pkt_len, 0);
    reset = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hD2;
    tick();
    rx_valid = 1'b0;
    tick();
    tick();
    rx_active = 1'b0;
    tick();
    tick();
    b = '{8'hD2};
    applyStimulus(b, -1, 2);
    checkBatch("after_reset");
  endtask

  task automatic genRandom(output bq_t b, output int err_idx);
    bq_t pl;
    int n;
    logic [7:0] p;
    b.delete();
    case ($urandom_range(9))
      0, 1, 2, 3: begin
        n = $urandom_range(8);
        for (int k = 0; k < n; k++) pl.push_back(8'($urandom));
        p = ($urandom_range(1) == 1) ? 8'hC3 : 8'h4B;
        b = makeData(p, pl, $urandom_range(4) == 0);
        if ($urandom_range(7) == 0) while (b.size() > 2) void'(b.pop_back());
      end
      4, 5: begin
        case ($urandom_range(3))
          0: p = 8'hE1;
          1: p = 8'h69;
          2: p = 8'hA5;
          default: p = 8'h2D;
        endcase
        b = makeToken(p, 11'($urandom), $urandom_range(3) == 0);
        if ($urandom_range(5) == 0) void'(b.pop_back());
        else if ($urandom_range(5) == 0) b.push_back(8'($urandom));
      end
      6, 7: begin
        case ($urandom_range(3))
          0: p = 8'hD2;
          1: p = 8'h5A;
          2: p = 8'h1E;
          default: p = 8'h96;
        endcase
        b.push_back(p);
        if ($urandom_range(4) == 0) b.push_back(8'($urandom));
      end
      8: begin
        n = $urandom_range(3);
        for (int k = 0; k <= n; k++) b.push_back(8'($urandom));
      end
      default: ;
    endcase
    err_idx = ($urandom_range(9) == 0) ? int'($urandom_range(b.size())) : -1;
  endtask

  initial begin
    bq_t b;
    bq_t pl;
    int  e;
    reset = 1'b0;
    repeat (3) tick();
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_pkt_done", pkt_done, 0);
    checkOutput("rst_pkt_ok", pkt_ok, 0);
    checkOutput("rst_pkt_pid", pkt_pid, 0);
    checkOutput("rst_pkt_len", pkt_len, 0);
    reset = 1'b1;
    tick();
    tick();

    b = '{8'h4B, 8'h00, 8'h00};
    applyStimulus(b, -1, 2);
    checkBatch("empty_data1");

    pl = '{8'h00, 8'h01, 8'h02, 8'h03};
    b = makeData(8'hC3, pl, 1'b0);
    applyStimulus(b, -1, 2);
    checkBatch("data0_good");

    resetMidPacket();

    b = makeData(8'hC3, pl, 1'b1);
    applyStimulus(b, -1, 2);
    checkBatch("data0_badcrc");

    b = '{8'hD2};
    applyStimulus(b, -1, 2);
    checkBatch("ack");
    b = '{8'hD2, 8'h00};
    applyStimulus(b, -1, 2);
    checkBatch("ack_extra");

    b = '{8'hC4, 8'h01, 8'h02, 8'h03};
    applyStimulus(b, -1, 2);
    checkBatch("bad_pid");

    b = '{8'h2D, 8'h00, 8'h10};
    applyStimulus(b, -1, 2);
    checkBatch("setup");
    b = '{8'h2D, 8'h00, 8'h11};
    applyStimulus(b, -1, 2);
    checkBatch("setup_crc5");

    b = makeData(8'hC3, pl, 1'b0);
    applyStimulus(b, 3, 2);
    checkBatch("rx_error_mid");
    b = makeData(8'h4B, pl, 1'b0);
    applyStimulus(b, b.size(), 2);
    checkBatch("rx_error_eop");

    b.delete();
    applyStimulus(b, -1, 2);
    checkBatch("pid_abort");

    pl.delete();
    for (int k = 0; k < MAX_LEN; k++) pl.push_back(8'($urandom));
    b = makeData(8'hC3, pl, 1'b0);
    applyStimulus(b, -1, 2);
    checkBatch("max_len");
    pl.push_back(8'($urandom));
    b = makeData(8'h4B, pl, 1'b0);
    applyStimulus(b, -1, 2);
    checkBatch("over_len");

    for (int batch = 0; batch < 4; batch++) begin
      for (int k = 0; k < 30; k++) begin
        genRandom(b, e);
        applyStimulus(b, e, int'($urandom_range(3, 1)));
      end
      checkBatch($sformatf("random%0d", batch));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
